// File: rtl/sd_block_responder_if.sv
// Virtual-disk block bus between the core, the sector responder and the byte-wide backing store.
// The master modport is the responder side; the slave modport is the core/memory side.
interface sd_block_responder_if #(
  parameter int VDNUM  = 4,
  parameter int ADDR_W = 25
);
  logic [32*VDNUM-1:0] sd_lba;
  logic [VDNUM-1:0]    sd_rd;
  logic [VDNUM-1:0]    sd_wr;
  logic [VDNUM-1:0]    sd_ack;
  logic [8:0]          sd_buff_addr;
  logic [7:0]          sd_buff_dout;
  logic [8*VDNUM-1:0]  sd_buff_din;
  logic                sd_buff_wr;
  logic [VDNUM-1:0]    img_readonly;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_rd;
  logic                mem_wr;
  logic [7:0]          mem_din;
  logic [7:0]          mem_dout;
  logic                mem_ready;

  modport master (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din, img_readonly, mem_dout, mem_ready,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_addr, mem_rd, mem_wr, mem_din
  );

  modport slave (
    output sd_lba, sd_rd, sd_wr, sd_buff_din, img_readonly, mem_dout, mem_ready,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_addr, mem_rd, mem_wr, mem_din
  );
endinterface

// File: rtl/sd_block_responder.sv
// Serves 512-byte sector reads/writes for VDNUM virtual drives from a byte-wide backing store.
// Define SDRESP_RO_EN to honour img_readonly (protected writes run full-length but never reach memory).
module sd_block_responder #(
  parameter int VDNUM       = 4,
  parameter int ADDR_W      = 25,
  parameter int DRIVE_SHIFT = 22
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  sd_block_responder_if.master bus,
  output logic                 busy
);
  localparam int DRV_W = (VDNUM > 1) ? $clog2(VDNUM) : 1;

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_ADDR, WR_DATA, WR_WAIT, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [DRV_W-1:0]  ptr_q, ptr_d;
  logic [DRV_W-1:0]  drive_q, drive_d;
  logic [31:0]       lba_q, lba_d;
  logic [8:0]        byteIdx_q, byteIdx_d;
  logic [8:0]        buffAddr_q, buffAddr_d;
  logic [7:0]        buffDout_q, buffDout_d;
  logic              buffWr_q, buffWr_d;
  logic [VDNUM-1:0]  ack_q, ack_d;

  logic              found, grantRd;
  logic [DRV_W-1:0]  grantIdx, grantNext;
  logic              memRd, memWr, wrBlock, memActive;
  logic [ADDR_W-1:0] baseAddr;

  // Round-robin scan starting at ptr_q; read wins over write on the same drive.
  always_comb begin
    int idx;
    idx       = 0;
    found     = 1'b0;
    grantRd   = 1'b0;
    grantIdx  = '0;
    grantNext = '0;
    for (int k = 0; k < VDNUM; k++) begin
      idx = (int'(ptr_q) + k) % VDNUM;
      if (!found && (bus.sd_rd[idx] || bus.sd_wr[idx])) begin
        found     = 1'b1;
        grantRd   = bus.sd_rd[idx];
        grantIdx  = DRV_W'(idx);
        grantNext = DRV_W'((idx + 1) % VDNUM);
      end
    end
  end

`ifdef SDRESP_RO_EN
  logic ro_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ro_q <= 1'b0;
    end else if (state_q == IDLE && found) begin
      ro_q <= bus.img_readonly[grantIdx] & ~grantRd;
    end
  end

  assign wrBlock = ro_q;
`else
  // Write protect is not built in; img_readonly is folded away so every write reaches the store.
  assign wrBlock = 1'b0 & (|bus.img_readonly);
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    drive_d    = drive_q;
    lba_d      = lba_q;
    byteIdx_d  = byteIdx_q;
    buffAddr_d = buffAddr_q;
    buffDout_d = buffDout_q;
    buffWr_d   = 1'b0;
    ack_d      = ack_q;
    memRd      = 1'b0;
    memWr      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          drive_d   = grantIdx;
          lba_d     = bus.sd_lba[32*grantIdx +: 32];
          ack_d     = VDNUM'(1) << grantIdx;
          byteIdx_d = 9'd0;
          ptr_d     = grantNext;
          state_d   = grantRd ? RD_REQ : WR_ADDR;
        end
      end
      RD_REQ: begin
        memRd   = 1'b1;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (bus.mem_ready) begin
          buffDout_d = bus.mem_dout;
          buffAddr_d = byteIdx_q;
          buffWr_d   = 1'b1;
          if (byteIdx_q == 9'd511) begin
            state_d = DONE;
          end else begin
            byteIdx_d = byteIdx_q + 9'd1;
            state_d   = RD_REQ;
          end
        end
      end
      WR_ADDR: begin
        buffAddr_d = byteIdx_q;
        state_d    = WR_DATA;
      end
      WR_DATA: begin
        memWr   = ~wrBlock;
        state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (bus.mem_ready || wrBlock) begin
          if (byteIdx_q == 9'd511) begin
            state_d = DONE;
          end else begin
            byteIdx_d = byteIdx_q + 9'd1;
            state_d   = WR_ADDR;
          end
        end
      end
      DONE: begin
        ack_d      = '0;
        buffAddr_d = 9'd0;
        buffDout_d = 8'd0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      drive_q    <= '0;
      lba_q      <= '0;
      byteIdx_q  <= '0;
      buffAddr_q <= '0;
      buffDout_q <= '0;
      buffWr_q   <= 1'b0;
      ack_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      drive_q    <= drive_d;
      lba_q      <= lba_d;
      byteIdx_q  <= byteIdx_d;
      buffAddr_q <= buffAddr_d;
      buffDout_q <= buffDout_d;
      buffWr_q   <= buffWr_d;
      ack_q      <= ack_d;
    end
  end

  // Address is driven only while a transfer is walking bytes so the bus idles at zero.
  assign baseAddr  = (ADDR_W'(drive_q) << DRIVE_SHIFT) | ADDR_W'({lba_q, 9'b0});
  assign memActive = (state_q != IDLE) && (state_q != DONE);

  assign bus.mem_addr     = memActive ? (baseAddr + ADDR_W'(byteIdx_q)) : '0;
  assign bus.mem_rd       = memRd;
  assign bus.mem_wr       = memWr;
  assign bus.mem_din      = memWr ? bus.sd_buff_din[8*drive_q +: 8] : 8'h00;
  assign bus.sd_ack       = ack_q;
  assign bus.sd_buff_addr = buffAddr_q;
  assign bus.sd_buff_dout = buffDout_q;
  assign bus.sd_buff_wr   = buffWr_q;
  assign busy             = (state_q != IDLE);
endmodule

// File: tb/tb_sd_block_responder.sv
// Directed bench for sd_block_responder: sector reads/writes, round robin, slow memory with reset, rd/wr priority, write protect.
module tb_sd_block_responder;
  logic clk_sys = 1'b0;
  logic reset;
  logic busy;
  logic slowMode;

  sd_block_responder_if #(.VDNUM(4), .ADDR_W(25)) bus ();

  sd_block_responder #(.VDNUM(4), .ADDR_W(25), .DRIVE_SHIFT(22)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus),
    .busy    (busy)
  );

  always #5 clk_sys = ~clk_sys;

  // Core buffer returns the complement of the byte index it is addressed with.
  assign bus.sd_buff_din = {4{~bus.sd_buff_addr[7:0]}};

  int compared = 0;
  int mismatched = 0;
  int rdPulses = 0, rdBad = 0, memRdCnt = 0, memWrCnt = 0, memBad = 0, ackLen = 0, overlap = 0;
  int grantLog[$];
  logic [8:0] lastBuf = '0, lastMem = '0;
  logic prevAck = 1'b0;
  logic pend;
  int delayCnt;
  logic [7:0] pendAddr;
  int sRd, sRb, sMr, sMw, sMb;

  function automatic int ackIndex(input logic [3:0] a);
    int r = -1;
    for (int i = 3; i >= 0; i--) if (a[i]) r = i;
    return r;
  endfunction

  // Upper store address bits for each drive: (drive << 22 | lba << 9) >> 9.
  function automatic logic [15:0] expectedHi(input int idx);
    int lba;
    case (idx)
      0: lba = 3;
      1: lba = 0;
      2: lba = 7;
      3: lba = 9;
      default: lba = 0;
    endcase
    return 16'((idx << 13) | lba);
  endfunction

  // Backing store: reads return addr[7:0]^0x5A one cycle after the pulse; byte 100 is 4 cycles slower in slowMode.
  always @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      bus.mem_ready <= 1'b0;
      bus.mem_dout  <= 8'h00;
      pend          <= 1'b0;
      delayCnt      <= 0;
      pendAddr      <= 8'h00;
    end else begin
      bus.mem_ready <= 1'b0;
      if (bus.mem_rd || bus.mem_wr) begin
        if (slowMode && bus.mem_addr[8:0] == 9'd100) begin
          pend     <= 1'b1;
          delayCnt <= 4;
          pendAddr <= bus.mem_addr[7:0];
        end else begin
          bus.mem_ready <= 1'b1;
          bus.mem_dout  <= bus.mem_addr[7:0] ^ 8'h5A;
        end
      end else if (pend) begin
        if (delayCnt == 1) begin
          bus.mem_ready <= 1'b1;
          bus.mem_dout  <= pendAddr ^ 8'h5A;
          pend          <= 1'b0;
        end else begin
          delayCnt <= delayCnt - 1;
        end
      end
    end
  end

  always @(negedge clk_sys) begin
    if (bus.sd_buff_wr) begin
      rdPulses <= rdPulses + 1;
      if (bus.sd_buff_dout !== (bus.sd_buff_addr[7:0] ^ 8'h5A) ||
          (bus.sd_buff_addr != 9'd0 && bus.sd_buff_addr != lastBuf + 9'd1))
        rdBad <= rdBad + 1;
      lastBuf <= bus.sd_buff_addr;
    end
    if (bus.mem_rd || bus.mem_wr) begin
      if (bus.mem_rd) memRdCnt <= memRdCnt + 1;
      if (bus.mem_wr) memWrCnt <= memWrCnt + 1;
      if (bus.mem_addr[24:9] !== expectedHi(ackIndex(bus.sd_ack)) ||
          (bus.mem_addr[8:0] != 9'd0 && bus.mem_addr[8:0] != lastMem + 9'd1) ||
          (bus.mem_wr && bus.mem_din !== ~bus.mem_addr[7:0]) || (bus.mem_rd && bus.mem_wr))
        memBad <= memBad + 1;
      lastMem <= bus.mem_addr[8:0];
    end
    if (|bus.sd_ack) begin
      if (!prevAck) begin
        grantLog.push_back(ackIndex(bus.sd_ack));
        ackLen <= 1;
      end else begin
        ackLen <= ackLen + 1;
      end
      if ($countones(bus.sd_ack) != 1) overlap <= overlap + 1;
    end
    prevAck <= |bus.sd_ack;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] rd, input logic [3:0] wr);
    @(negedge clk_sys);
    bus.sd_rd = rd;
    bus.sd_wr = wr;
  endtask

  task automatic waitAck(input logic level, input int budget, input string tag);
    int n = 0;
    while (((|bus.sd_ack) !== level) && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    checkOutput({tag, "_reached"}, 64'((|bus.sd_ack) === level), 64'd1);
  endtask

  task automatic snap();
    sRd = rdPulses; sRb = rdBad; sMr = memRdCnt; sMw = memWrCnt; sMb = memBad;
  endtask

  initial begin
    int n;
    int g0;
    reset = 1'b0;
    slowMode = 1'b0;
    bus.sd_rd = '0;
    bus.sd_wr = '0;
    bus.img_readonly = '0;
    bus.sd_lba = {32'd9, 32'd7, 32'd0, 32'd3};
    #2 reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    checkOutput("reset_ack", bus.sd_ack, 4'b0000);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_mem_rd", bus.mem_rd, 1'b0);
    checkOutput("reset_mem_wr", bus.mem_wr, 1'b0);
    checkOutput("reset_buff_wr", bus.sd_buff_wr, 1'b0);
    checkOutput("reset_mem_addr", bus.mem_addr, 25'd0);
    checkOutput("reset_buff_addr", bus.sd_buff_addr, 9'd0);
    reset = 1'b0;

    // Sector read, drive 0 lba 3 (store base 0x600).
    snap();
    applyStimulus(4'b0001, 4'b0000);
    waitAck(1'b1, 20, "rd0_grant");
    checkOutput("rd0_ack", bus.sd_ack, 4'b0001);
    checkOutput("rd0_busy", busy, 1'b1);
    bus.sd_rd = '0;
    waitAck(1'b0, 2000, "rd0_done");
    #1;
    checkOutput("rd0_buff_wr_count", rdPulses - sRd, 512);
    checkOutput("rd0_mem_rd_count", memRdCnt - sMr, 512);
    checkOutput("rd0_data_errors", rdBad - sRb, 0);
    checkOutput("rd0_addr_errors", memBad - sMb, 0);
    checkOutput("rd0_ack_cycles", ackLen, 1025);
    checkOutput("rd0_idle", busy, 1'b0);

    // Sector write, drive 1 lba 0 (store base 1<<22).
    snap();
    applyStimulus(4'b0000, 4'b0010);
    waitAck(1'b1, 20, "wr1_grant");
    checkOutput("wr1_ack", bus.sd_ack, 4'b0010);
    bus.sd_wr = '0;
    waitAck(1'b0, 3000, "wr1_done");
    #1;
    checkOutput("wr1_mem_wr_count", memWrCnt - sMw, 512);
    checkOutput("wr1_addr_data_errors", memBad - sMb, 0);
    checkOutput("wr1_ack_cycles", ackLen, 1537);
    checkOutput("wr1_no_buff_wr", rdPulses - sRd, 0);

    // Round robin from ptr 0 over simultaneous reads on drives 0, 1, 3.
    @(negedge clk_sys) reset = 1'b1;
    @(negedge clk_sys) reset = 1'b0;
    snap();
    g0 = grantLog.size();
    applyStimulus(4'b1011, 4'b0000);
    for (int t = 0; t < 3; t++) begin
      waitAck(1'b1, 20, "rr_grant");
      bus.sd_rd = bus.sd_rd & ~bus.sd_ack;
      waitAck(1'b0, 2000, "rr_done");
    end
    #1;
    checkOutput("rr_grant_count", grantLog.size() - g0, 3);
    checkOutput("rr_first", grantLog[g0], 0);
    checkOutput("rr_second", grantLog[g0 + 1], 1);
    checkOutput("rr_third", grantLog[g0 + 2], 3);
    checkOutput("rr_overlap", overlap, 0);
    checkOutput("rr_buff_wr_count", rdPulses - sRd, 1536);
    checkOutput("rr_addr_errors", memBad - sMb, 0);

    // Slow byte 100, then reset while byte 200 is being delivered.
    slowMode = 1'b1;
    applyStimulus(4'b0001, 4'b0000);
    waitAck(1'b1, 20, "slow_grant");
    bus.sd_rd = '0;
    n = 0;
    while (!(bus.sd_buff_wr === 1'b1 && bus.sd_buff_addr === 9'd200) && n < 2000) begin
      @(negedge clk_sys);
      n++;
    end
    checkOutput("slow_byte200_cycle", n, 406);
    reset = 1'b1;
    #1;
    checkOutput("midreset_ack", bus.sd_ack, 4'b0000);
    checkOutput("midreset_busy", busy, 1'b0);
    checkOutput("midreset_buff_wr", bus.sd_buff_wr, 1'b0);
    checkOutput("midreset_mem_rd", bus.mem_rd, 1'b0);
    checkOutput("midreset_mem_addr", bus.mem_addr, 25'd0);
    checkOutput("midreset_buff_addr", bus.sd_buff_addr, 9'd0);
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    slowMode = 1'b0;
    snap();
    applyStimulus(4'b0100, 4'b0000);
    waitAck(1'b1, 20, "postreset_grant");
    checkOutput("postreset_ack", bus.sd_ack, 4'b0100);
    bus.sd_rd = '0;
    waitAck(1'b0, 2000, "postreset_done");
    #1;
    checkOutput("postreset_buff_wr_count", rdPulses - sRd, 512);
    checkOutput("postreset_data_errors", rdBad - sRb, 0);
    checkOutput("postreset_addr_errors", memBad - sMb, 0);
    checkOutput("postreset_ack_cycles", ackLen, 1025);

    // Read and write together on drive 2: read first, write on the following grant.
    snap();
    applyStimulus(4'b0100, 4'b0100);
    waitAck(1'b1, 20, "rdwr_first_grant");
    checkOutput("rdwr_first_ack", bus.sd_ack, 4'b0100);
    checkOutput("rdwr_first_is_read", bus.mem_rd, 1'b1);
    bus.sd_rd = '0;
    waitAck(1'b0, 2000, "rdwr_first_done");
    #1;
    checkOutput("rdwr_read_bytes", rdPulses - sRd, 512);
    checkOutput("rdwr_read_no_mem_wr", memWrCnt - sMw, 0);
    snap();
    waitAck(1'b1, 20, "rdwr_second_grant");
    checkOutput("rdwr_second_ack", bus.sd_ack, 4'b0100);
    bus.sd_wr = '0;
    waitAck(1'b0, 3000, "rdwr_second_done");
    #1;
    checkOutput("rdwr_write_pulses", memWrCnt - sMw, 512);
    checkOutput("rdwr_write_no_buff_wr", rdPulses - sRd, 0);
    checkOutput("rdwr_addr_errors", memBad - sMb, 0);

    // Write to drive 0 with img_readonly[0] set.
    bus.img_readonly = 4'b0001;
    snap();
    applyStimulus(4'b0000, 4'b0001);
    waitAck(1'b1, 20, "ro_grant");
    checkOutput("ro_ack", bus.sd_ack, 4'b0001);
    bus.sd_wr = '0;
    waitAck(1'b0, 3000, "ro_done");
    #1;
`ifdef SDRESP_RO_EN
    checkOutput("ro_mem_wr_suppressed", memWrCnt - sMw, 0);
`else
    checkOutput("ro_ignored_mem_wr", memWrCnt - sMw, 512);
`endif
    checkOutput("ro_ack_cycles", ackLen, 1537);
    checkOutput("ro_addr_errors", memBad - sMb, 0);
    bus.img_readonly = '0;

    repeat (2) @(negedge clk_sys);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
